br_redirect: RTL and testbench
==============================

# br_redirect

Collects branch-mispredict packets from every integer branch unit and holds the oldest outstanding one. When that branch retires from the ROB head, the block issues a single redirect (fetch PC or ucode ROM address) to the front end with a valid/ready handshake, then pulses a pipeline flush. It sits between the EX-stage branch units and the fetch/ucode sequencer, next to the ROB retire logic.

## Interface
Parameters:
- NUM_BR_PORTS, 2, number of branch units feeding mispredict packets
- ROBID_W, 6, ROB id width
- PADDR_W, 64, target address width (t_paddr)

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- mispred_vld  in  NUM_BR_PORTS  per-port mispredict valid
- mispred_tgt  in  NUM_BR_PORTS*PADDR_W  per-port true target (port i at bits [i*PADDR_W +: PADDR_W])
- mispred_robid  in  NUM_BR_PORTS*ROBID_W  per-port ROB id of the branch
- mispred_ucbr  in  NUM_BR_PORTS  per-port: target is a ucode ROM address, not a PC
- rob_head_robid  in  ROBID_W  ROB id currently at head
- rob_retire  in  1  head entry retires this cycle
- redir_valid  out  1  redirect request to front end
- redir_ready  in  1  front end accepts redirect
- redir_addr  out  PADDR_W  redirect target
- redir_ucbr  out  1  redirect goes to ucode sequencer
- flush_pulse  out  1  one-cycle flush of all in-flight work
- busy  out  1  state != IDLE
- stat_mispreds  out  32  accepted-packet count (macro-gated)
- stat_redirects  out  32  completed-redirect count (macro-gated)

## Operation
- States: IDLE, PEND, SEND, FLUSH.
- Age of a packet = (robid - rob_head_robid) mod 2^ROBID_W, unsigned; smaller is older.
- Per-cycle selection: among valid ports, pick smallest age; tie goes to the lowest port index.
- IDLE: any valid port -> capture selected {tgt, robid, ucbr} -> PEND.
- PEND: a selected incoming packet strictly older than the held one replaces it. Equal age keeps the held packet. If rob_retire && rob_head_robid == held robid -> SEND. When retire-match and an incoming packet arrive in the same cycle, the retire wins and the incoming packet is dropped (it is younger and will be flushed).
- SEND: redir_valid=1, redir_addr/redir_ucbr = held values, stable until handshake. All mispredict inputs ignored. valid&&ready -> FLUSH.
- FLUSH: flush_pulse=1 for exactly this cycle; inputs ignored; -> IDLE.
- ROB contract: a branch never retires in the same cycle its mispredict packet is presented. The block does not handle this case.
- Reset (any state, mid-handshake included): state=IDLE, held regs=0, redir_valid=0, redir_addr=0, redir_ucbr=0, flush_pulse=0, busy=0, stats=0. Pending packets are lost.

## Timing
- Packet in cycle N -> held (busy=1) in N+1.
- Retire-match in cycle M -> redir_valid=1 in M+1.
- Handshake in cycle K -> flush_pulse=1 in K+1, busy=0 and able to capture in K+2.
- Minimum mispredict-to-redirect latency: 2 cycles (capture + retire-match). All outputs registered.

## Configuration
- BR_REDIRECT_STATS_EN defined: stat_mispreds increments on each IDLE capture or PEND replacement. stat_redirects increments on each SEND handshake. Both wrap at 2^32.
- Undefined: counters are not built; both stat ports tie to 0.

## Test plan
- Single mispred port0 robid=5 tgt=0x1000, head reaches 5 and retires, ready=1 -> redir_valid in retire+1 with addr 0x1000, ucbr=0, flush_pulse next cycle, busy drops.
- Same cycle, head=60: port0 robid=2, port1 robid=62 -> port1 held (age 2 < age 6). Later arrival robid=61 replaces it; redirect targets robid 61.
- Equal robid on both ports -> port0 values held.
- SEND with redir_ready=0 for 5 cycles while new mispreds arrive -> redir_valid/addr stable, mispreds ignored, single flush after ready.
- ucbr packet rom target 0x3A -> redir_ucbr=1, redir_addr=0x3A. Reset asserted during SEND -> all outputs 0 immediately, no flush_pulse.
- With BR_REDIRECT_STATS_EN: 3 captures, 1 replacement, 2 redirects -> stat_mispreds=4, stat_redirects=2. Without the macro: both stat ports 0.

Source files
------------

// File: rtl/br_redirect.sv
// br_redirect
//   Collects branch-mispredict packets from every integer branch unit and holds
//   the oldest outstanding one. When that branch retires at the ROB head, a
//   single redirect (fetch PC or ucode ROM address) is sent to the front end
//   over a valid/ready handshake. A one-cycle flush pulse follows the redirect.
//
// Ports
//   clk, reset           core clock, asynchronous active-high reset
//   mispred_vld/tgt/robid/ucbr
//                        per-port mispredict packets (port i in slice i)
//   rob_head_robid       ROB id currently at the head
//   rob_retire           head entry retires this cycle
//   redir_valid/ready    redirect handshake to the front end
//   redir_addr/ucbr      redirect target, and whether it is a ucode ROM address
//   flush_pulse          one-cycle flush of all in-flight work
//   busy                 FSM is not idle
//   stat_mispreds        accepted-packet count (BR_REDIRECT_STATS_EN)
//   stat_redirects       completed-redirect count (BR_REDIRECT_STATS_EN)
//
// Configuration macro: BR_REDIRECT_STATS_EN builds the statistics counters;
// without it both stat ports are tied to zero.
module br_redirect #(
  parameter int unsigned NUM_BR_PORTS = 2,
  parameter int unsigned ROBID_W      = 6,
  parameter int unsigned PADDR_W      = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_BR_PORTS-1:0]         mispred_vld,
  input  logic [NUM_BR_PORTS*PADDR_W-1:0] mispred_tgt,
  input  logic [NUM_BR_PORTS*ROBID_W-1:0] mispred_robid,
  input  logic [NUM_BR_PORTS-1:0]         mispred_ucbr,
  input  logic [ROBID_W-1:0]              rob_head_robid,
  input  logic                            rob_retire,
  output logic                            redir_valid,
  input  logic                            redir_ready,
  output logic [PADDR_W-1:0]              redir_addr,
  output logic                            redir_ucbr,
  output logic                            flush_pulse,
  output logic                            busy,
  output logic [31:0]                     stat_mispreds,
  output logic [31:0]                     stat_redirects
);

  typedef enum logic [1:0] {StIdle, StPend, StSend, StFlush} state_e;

  state_e               state_q;
  logic [PADDR_W-1:0]   held_tgt_q;
  logic [ROBID_W-1:0]   held_robid_q;
  logic                 held_ucbr_q;
  logic                 redir_valid_q;
  logic [PADDR_W-1:0]   redir_addr_q;
  logic                 redir_ucbr_q;
  logic                 flush_pulse_q;
  logic                 busy_q;

  // Oldest valid incoming packet this cycle; ties go to the lowest port.
  logic                 sel_vld;
  logic [PADDR_W-1:0]   sel_tgt;
  logic [ROBID_W-1:0]   sel_robid;
  logic                 sel_ucbr;
  logic [ROBID_W-1:0]   sel_age;
  logic [ROBID_W-1:0]   port_age;

  always_comb begin
    sel_vld   = 1'b0;
    sel_tgt   = '0;
    sel_robid = '0;
    sel_ucbr  = 1'b0;
    sel_age   = '0;
    port_age  = '0;
    for (int i = 0; i < NUM_BR_PORTS; i++) begin
      // Modular distance from the head: wraps correctly across the ROB id space.
      port_age = mispred_robid[i*ROBID_W +: ROBID_W] - rob_head_robid;
      if (mispred_vld[i] && (!sel_vld || (port_age < sel_age))) begin
        sel_vld   = 1'b1;
        sel_tgt   = mispred_tgt[i*PADDR_W +: PADDR_W];
        sel_robid = mispred_robid[i*ROBID_W +: ROBID_W];
        sel_ucbr  = mispred_ucbr[i];
        sel_age   = port_age;
      end
    end
  end

  logic [ROBID_W-1:0] held_age;
  logic               retire_hit;
  logic               replace;

  assign held_age   = held_robid_q - rob_head_robid;
  assign retire_hit = rob_retire && (rob_head_robid == held_robid_q);
  // Retire wins over a same-cycle arrival: the arrival is younger and gets flushed.
  assign replace    = !retire_hit && sel_vld && (sel_age < held_age);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      held_tgt_q    <= '0;
      held_robid_q  <= '0;
      held_ucbr_q   <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_addr_q  <= '0;
      redir_ucbr_q  <= 1'b0;
      flush_pulse_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (sel_vld) begin
            held_tgt_q   <= sel_tgt;
            held_robid_q <= sel_robid;
            held_ucbr_q  <= sel_ucbr;
            busy_q       <= 1'b1;
            state_q      <= StPend;
          end
        end
        StPend: begin
          if (retire_hit) begin
            redir_valid_q <= 1'b1;
            redir_addr_q  <= held_tgt_q;
            redir_ucbr_q  <= held_ucbr_q;
            state_q       <= StSend;
          end else if (replace) begin
            held_tgt_q   <= sel_tgt;
            held_robid_q <= sel_robid;
            held_ucbr_q  <= sel_ucbr;
          end
        end
        StSend: begin
          if (redir_ready) begin
            redir_valid_q <= 1'b0;
            flush_pulse_q <= 1'b1;
            state_q       <= StFlush;
          end
        end
        StFlush: begin
          flush_pulse_q <= 1'b0;
          busy_q        <= 1'b0;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign redir_valid = redir_valid_q;
  assign redir_addr  = redir_addr_q;
  assign redir_ucbr  = redir_ucbr_q;
  assign flush_pulse = flush_pulse_q;
  assign busy        = busy_q;

`ifdef BR_REDIRECT_STATS_EN
  logic        cap_evt;
  logic        red_evt;
  logic [31:0] stat_mispreds_q;
  logic [31:0] stat_redirects_q;

  assign cap_evt = ((state_q == StIdle) && sel_vld) || ((state_q == StPend) && replace);
  assign red_evt = (state_q == StSend) && redir_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_mispreds_q  <= '0;
      stat_redirects_q <= '0;
    end else begin
      if (cap_evt) stat_mispreds_q <= stat_mispreds_q + 32'd1;
      if (red_evt) stat_redirects_q <= stat_redirects_q + 32'd1;
    end
  end

  assign stat_mispreds  = stat_mispreds_q;
  assign stat_redirects = stat_redirects_q;
`else
  assign stat_mispreds  = 32'd0;
  assign stat_redirects = 32'd0;
`endif

endmodule

// File: tb/tb_br_redirect.sv
module tb_br_redirect;
  localparam int unsigned NP = 2;
  localparam int unsigned RW = 6;
  localparam int unsigned PW = 64;

  logic               clk = 1'b0;
  logic               reset;
  logic [NP-1:0]      mispred_vld;
  logic [NP*PW-1:0]   mispred_tgt;
  logic [NP*RW-1:0]   mispred_robid;
  logic [NP-1:0]      mispred_ucbr;
  logic [RW-1:0]      rob_head_robid;
  logic               rob_retire;
  logic               redir_valid;
  logic               redir_ready;
  logic [PW-1:0]      redir_addr;
  logic               redir_ucbr;
  logic               flush_pulse;
  logic               busy;
  logic [31:0]        stat_mispreds;
  logic [31:0]        stat_redirects;

  br_redirect #(.NUM_BR_PORTS(NP), .ROBID_W(RW), .PADDR_W(PW)) dut (
    .clk            (clk),
    .reset          (reset),
    .mispred_vld    (mispred_vld),
    .mispred_tgt    (mispred_tgt),
    .mispred_robid  (mispred_robid),
    .mispred_ucbr   (mispred_ucbr),
    .rob_head_robid (rob_head_robid),
    .rob_retire     (rob_retire),
    .redir_valid    (redir_valid),
    .redir_ready    (redir_ready),
    .redir_addr     (redir_addr),
    .redir_ucbr     (redir_ucbr),
    .flush_pulse    (flush_pulse),
    .busy           (busy),
    .stat_mispreds  (stat_mispreds),
    .stat_redirects (stat_redirects)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] addr;
    logic          ucbr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_mis = 0;
  int   exp_red = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [PW-1:0] tgt, input logic [RW-1:0] robid,
                          input logic ucbr);
    mispred_vld[p]               = 1'b1;
    mispred_tgt[p*PW +: PW]      = tgt;
    mispred_robid[p*RW +: RW]    = robid;
    mispred_ucbr[p]              = ucbr;
  endtask

  task automatic clr_ports();
    mispred_vld   = '0;
    mispred_tgt   = '0;
    mispred_robid = '0;
    mispred_ucbr  = '0;
  endtask

  task automatic chk_stats(input string tag);
`ifdef BR_REDIRECT_STATS_EN
    chk({tag, "_stat_mis"}, 64'(stat_mispreds), 64'(exp_mis));
    chk({tag, "_stat_red"}, 64'(stat_redirects), 64'(exp_red));
`else
    chk({tag, "_stat_mis"}, 64'(stat_mispreds), 64'd0);
    chk({tag, "_stat_red"}, 64'(stat_redirects), 64'd0);
`endif
  endtask

  // Waits (bounded) for redir_valid, then pops the scoreboard and compares.
  task automatic sb_check(input string tag);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (!redir_valid && cyc < 10) begin
      step();
      cyc++;
    end
    n_cmp++;
    if (!redir_valid) begin
      n_err++;
      $error("FAIL %s_timeout: redir_valid never rose within 10 cycles", tag);
    end else if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL %s_sb_empty: redirect observed with no expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      n_cmp--;
      chk({tag, "_addr"}, redir_addr, e.addr);
      chk({tag, "_ucbr"}, 64'(redir_ucbr), 64'(e.ucbr));
    end
  endtask

  task automatic do_redirect(input string tag);
    sb_check(tag);
    redir_ready = 1'b1;
    step();
    redir_ready = 1'b0;
    exp_red++;
    chk({tag, "_flush"}, 64'(flush_pulse), 64'd1);
    chk({tag, "_vld_drop"}, 64'(redir_valid), 64'd0);
    step();
    chk({tag, "_flush_end"}, 64'(flush_pulse), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic retire(input logic [RW-1:0] head);
    rob_head_robid = head;
    rob_retire     = 1'b1;
    step();
    rob_retire     = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    redir_ready = 1'b0;
    rob_retire  = 1'b0;
    rob_head_robid = '0;
    clr_ports();
    step();
    step();
    chk("rst_valid", 64'(redir_valid), 64'd0);
    chk("rst_addr", redir_addr, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flush", 64'(flush_pulse), 64'd0);
    reset = 1'b0;
    step();
    chk_stats("rst");

    // Single mispredict, port 0
    set_port(0, 64'h1000, 6'd5, 1'b0);
    sb_q.push_back('{addr: 64'h1000, ucbr: 1'b0});
    exp_mis++;
    step();
    clr_ports();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_no_early", 64'(redir_valid), 64'd0);
    retire(6'd5);
    chk("t1_latency", 64'(redir_valid), 64'd1);
    do_redirect("t1");

    // Wrapped age: robid 62 (age 2) beats robid 2 (age 6) at head 60
    rob_head_robid = 6'd60;
    set_port(0, 64'h2002, 6'd2, 1'b0);
    set_port(1, 64'h2062, 6'd62, 1'b0);
    sb_q.push_back('{addr: 64'h2062, ucbr: 1'b0});
    exp_mis++;
    step();
    clr_ports();
    retire(6'd62);
    do_redirect("t2a");

    // Same pair, then robid 61 replaces; a retire at head 60 must not match
    rob_head_robid = 6'd60;
    set_port(0, 64'h2002, 6'd2, 1'b0);
    set_port(1, 64'h2062, 6'd62, 1'b0);
    exp_mis++;
    step();
    clr_ports();
    set_port(0, 64'h2061, 6'd61, 1'b0);
    sb_q.push_back('{addr: 64'h2061, ucbr: 1'b0});
    exp_mis++;
    step();
    clr_ports();
    retire(6'd60);
    chk("t2b_nomatch", 64'(redir_valid), 64'd0);
    retire(6'd61);
    do_redirect("t2b");

    // Equal robid on both ports: port 0 wins; equal-age arrival keeps the held packet
    rob_head_robid = 6'd0;
    set_port(0, 64'h00A0, 6'd10, 1'b0);
    set_port(1, 64'h00B1, 6'd10, 1'b1);
    sb_q.push_back('{addr: 64'h00A0, ucbr: 1'b0});
    exp_mis++;
    step();
    clr_ports();
    set_port(1, 64'h00C0, 6'd10, 1'b1);
    step();
    clr_ports();
    chk_stats("t3");
    retire(6'd10);
    do_redirect("t3");

    // Back-pressure: ready low for 5 cycles while new mispredicts arrive
    rob_head_robid = 6'd0;
    set_port(1, 64'h4000, 6'd3, 1'b0);
    sb_q.push_back('{addr: 64'h4000, ucbr: 1'b0});
    exp_mis++;
    step();
    clr_ports();
    retire(6'd3);
    for (int c = 0; c < 5; c++) begin
      set_port(0, 64'h5555, 6'd1, 1'b0);
      step();
      chk("t4_hold_vld", 64'(redir_valid), 64'd1);
      chk("t4_hold_addr", redir_addr, 64'h4000);
      chk("t4_no_flush", 64'(flush_pulse), 64'd0);
    end
    clr_ports();
    do_redirect("t4");
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t4_single_flush", 64'(flush_pulse), 64'd0);
      chk("t4_ignored", 64'(busy), 64'd0);
    end
    chk_stats("t4");

    // ucode target, then reset in the middle of SEND
    rob_head_robid = 6'd0;
    set_port(0, 64'h003A, 6'd7, 1'b1);
    sb_q.push_back('{addr: 64'h003A, ucbr: 1'b1});
    exp_mis++;
    step();
    clr_ports();
    retire(6'd7);
    sb_check("t5");
    reset = 1'b1;
    #1;
    exp_mis = 0;
    exp_red = 0;
    chk("t5_rst_valid", 64'(redir_valid), 64'd0);
    chk("t5_rst_addr", redir_addr, 64'd0);
    chk("t5_rst_ucbr", 64'(redir_ucbr), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk_stats("t5_rst");
    step();
    reset = 1'b0;
    redir_ready = 1'b1;
    step();
    chk("t5_no_flush", 64'(flush_pulse), 64'd0);
    chk("t5_still_idle", 64'(redir_valid), 64'd0);
    redir_ready = 1'b0;

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
